// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin register-file write arbiter with a 31-register clear sequencer; all outputs registered, latency 1 edge.
// No backpressure into the register file; requesters hold req until their one-cycle gnt, and clear locks out grants until it finishes.
module regfile_write_arbiter #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [4:0]           waddr0,
    input  logic [DATAWIDTH-1:0] wdata0,
    input  logic                 req1,
    input  logic [4:0]           waddr1,
    input  logic [DATAWIDTH-1:0] wdata1,
    input  logic                 clr_start,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rf_write,
    output logic [4:0]           rf_writeReg,
    output logic [DATAWIDTH-1:0] rf_writeData,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state;
    logic       prio1;    // requester 1 wins a tie (requester 0 was granted last)
    logic [4:0] clr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prio1        <= 1'b0;
            clr_cnt      <= 5'd0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rf_write     <= 1'b0;
            rf_writeReg  <= 5'd0;
            rf_writeData <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rf_write     <= 1'b0;
            rf_writeReg  <= 5'd0;
            rf_writeData <= '0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        clr_cnt     <= 5'd1;
                        rf_write    <= 1'b1;
                        rf_writeReg <= 5'd1;
                    end else if (req0 && (!req1 || !prio1)) begin
                        gnt0         <= 1'b1;
                        rf_write     <= (waddr0 != 5'd0);
                        rf_writeReg  <= waddr0;
                        rf_writeData <= wdata0;
                        prio1        <= 1'b1;
                    end else if (req1) begin
                        gnt1         <= 1'b1;
                        rf_write     <= (waddr1 != 5'd0);
                        rf_writeReg  <= waddr1;
                        rf_writeData <= wdata1;
                        prio1        <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Stop after register 31 rather than letting the counter wrap to 0.
                    if (clr_cnt == 5'd31) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        clr_cnt <= 5'd0;
                    end else begin
                        clr_cnt     <= clr_cnt + 5'd1;
                        rf_write    <= 1'b1;
                        rf_writeReg <= clr_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected output events, a monitor pops and compares them.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, clr_start = 1'b0;
    logic [4:0]  waddr0 = 5'd0, waddr1 = 5'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        gnt0, gnt1, rf_write, busy, done;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;

    regfile_write_arbiter #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .waddr0(waddr0), .wdata0(wdata0),
        .req1(req1), .waddr1(waddr1), .wdata1(wdata1),
        .clr_start(clr_start),
        .gnt0(gnt0), .gnt1(gnt1), .rf_write(rf_write),
        .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        cyc;
        bit        g0, g1, wr;
        bit [4:0]  addr;
        bit [31:0] dat;
        bit        bsy, dn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Reference model: next clear address (0 when not clearing) and last granted requester (-1 after reset).
    int   m_clr = 0;
    int   m_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input bit c, input bit r0, input bit [4:0] a0, input bit [31:0] d0,
                        input bit r1, input bit [4:0] a1, input bit [31:0] d1);
        exp_t e;
        int   w;
        @(negedge clk);
        clr_start = c; req0 = r0; waddr0 = a0; wdata0 = d0;
        req1 = r1; waddr1 = a1; wdata1 = d1;
        e.cyc = cyc + 1; e.g0 = 0; e.g1 = 0; e.wr = 0; e.addr = 0; e.dat = 0; e.bsy = 0; e.dn = 0;
        if (m_clr != 0) begin
            if (m_clr <= 31) begin
                e.wr = 1; e.addr = m_clr[4:0]; e.bsy = 1;
                m_clr++;
            end else begin
                e.dn = 1;
                m_clr = 0;
            end
        end else if (c) begin
            e.wr = 1; e.addr = 5'd1; e.bsy = 1;
            m_clr = 2;
        end else if (r0 || r1) begin
            if (r0 && r1) w = (m_last == 0) ? 1 : 0;
            else          w = r0 ? 0 : 1;
            m_last = w;
            e.g0   = (w == 0);
            e.g1   = (w == 1);
            e.addr = (w == 1) ? a1 : a0;
            e.dat  = (w == 1) ? d1 : d0;
            e.wr   = (e.addr != 5'd0);
        end
        if (e.g0 || e.g1 || e.wr || e.bsy || e.dn) q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset pulse placed mid-cycle, away from any clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (gnt0 || gnt1 || rf_write || rf_writeReg != 5'd0 || rf_writeData != 32'd0 || busy || done) begin
            bad++;
            $display("FAIL %s: outputs under async reset g0=%b g1=%b wr=%b reg=%0d dat=%h busy=%b done=%b, required all 0",
                     tag, gnt0, gnt1, rf_write, rf_writeReg, rf_writeData, busy, done);
        end
        q.delete();
        m_clr = 0;
        m_last = -1;
        req0 = 0; req1 = 0; clr_start = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: any active output must match the queue head, stamped with the same cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    total++; bad++;
                    $display("FAIL missing_output: expected event for cycle %0d not seen (now %0d)", q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                if (gnt0 || gnt1 || rf_write || busy || done) begin
                    total++;
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        bad++;
                        $display("FAIL unexpected_output cyc=%0d: g0=%b g1=%b wr=%b reg=%0d busy=%b done=%b, required idle",
                                 cyc, gnt0, gnt1, rf_write, rf_writeReg, busy, done);
                    end else begin
                        e = q.pop_front();
                        if (gnt0 !== e.g0 || gnt1 !== e.g1 || rf_write !== e.wr || rf_writeReg !== e.addr ||
                            rf_writeData !== e.dat || busy !== e.bsy || done !== e.dn) begin
                            bad++;
                            $display("FAIL output cyc=%0d: got g0=%b g1=%b wr=%b reg=%0d dat=%h busy=%b done=%b, required g0=%b g1=%b wr=%b reg=%0d dat=%h busy=%b done=%b",
                                     cyc, gnt0, gnt1, rf_write, rf_writeReg, rf_writeData, busy, done,
                                     e.g0, e.g1, e.wr, e.addr, e.dat, e.bsy, e.dn);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single write, then idle the cycle after.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Async reset with a grant on the outputs.
        step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'd0);
        async_reset("reset_during_grant");

        // Both requesting for six edges: alternate starting with requester 0.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'd3, 32'hA000_0000 + i, 1'b1, 5'd4, 32'hB000_0000 + i);
        idle(1);

        // Write to register 0 is granted but suppressed.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFEF00D);
        idle(1);

        // Clear with req0 held; clr_start again at E31 must be ignored.
        step(1'b1, 1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 33; i++)
            step(i == 31, 1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Reset on the tenth clear cycle, then a full clear from address 1.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(9);
        async_reset("reset_mid_clear");
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(33);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 500; n++) begin
            bit        c, r0, r1;
            bit [4:0]  a0, a1;
            c  = ($urandom_range(39) == 0);
            r0 = 1'($urandom_range(1));
            r1 = 1'($urandom_range(1));
            a0 = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            a1 = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            step(c, r0, a0, $urandom, r1, a1, $urandom);
        end
        idle(35);

        @(posedge clk);
        #2;
        while (q.size() > 0) begin
            total++; bad++;
            $display("FAIL missing_output_at_end: expected event for cycle %0d never seen", q[0].cyc);
            void'(q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
